// File: rtl/mux_serializer.sv
// Parallel-to-serial front stage: takes a W-bit word over valid/ready and emits
// it one bit per accepted transfer through a W:1 mux indexed by a bit counter.
module mux_serializer #(
   parameter int W         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   input  logic [W-1:0] up_data,
   output logic         up_ready,
   output logic         down_valid,
   output logic         down_data,
   output logic         down_last,
   input  logic         down_ready,
   output logic         state_dbg
);

   localparam int            CW       = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t         state;
   logic [W-1:0]   word;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_nxt;
   logic           up_fire;
   logic           down_fire;

   // Handshakes: a transfer happens on a cycle where valid && ready; once
   // down_valid rises it stays high, with data/last stable, until down_fire.
   assign up_fire   = up_valid && up_ready;
   assign down_fire = down_valid && down_ready;
   assign up_ready  = (state == IDLE) || (down_fire && down_last);
   assign cnt_nxt   = cnt + 1'b1;
   assign state_dbg = (state == SHIFT);

   function automatic logic sel_bit(input logic [W-1:0] w, input logic [CW-1:0] c);
      logic [CW-1:0] idx;
      idx = MSB_FIRST ? (LAST_CNT - c) : c;
      return w[idx];
   endfunction

   // Outputs are registered, so the next bit is looked up one cycle ahead.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         word       <= '0;
         cnt        <= '0;
         down_valid <= 1'b0;
         down_data  <= 1'b0;
         down_last  <= 1'b0;
      end else if (up_fire) begin
         state      <= SHIFT;
         word       <= up_data;
         cnt        <= '0;
         down_valid <= 1'b1;
         down_data  <= sel_bit(up_data, '0);
         down_last  <= 1'b0;
      end else if (down_fire) begin
         if (down_last) begin
            state      <= IDLE;
            cnt        <= '0;
            down_valid <= 1'b0;
            down_data  <= 1'b0;
            down_last  <= 1'b0;
         end else begin
            cnt       <= cnt_nxt;
            down_data <= sel_bit(word, cnt_nxt);
            down_last <= (cnt_nxt == LAST_CNT);
         end
      end
   end

endmodule

// File: tb/tb_mux_serializer.sv
// Bench for mux_serializer: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked every cycle against a bit-queue model.
module tb_mux_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         up_valid = 1'b0;
   logic [W-1:0] up_data = '0;
   logic         down_ready = 1'b0;

   logic ur_m, dv_m, dd_m, dl_m, st_m;
   logic ur_l, dv_l, dd_l, dl_l, st_l;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   // model: pending serial bits for each instance, head is the bit on the wire
   logic exp_m[$];
   logic exp_l[$];
   // capture of what each DUT actually transferred
   logic cap_m[$];
   logic cap_l[$];
   logic lst_m[$];
   int   fire_cyc[$];

   always #5 clk = ~clk;

   mux_serializer #(.W(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_ready(ur_m),
      .down_valid(dv_m), .down_data(dd_m), .down_last(dl_m), .down_ready(down_ready),
      .state_dbg(st_m)
   );

   mux_serializer #(.W(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_ready(ur_l),
      .down_valid(dv_l), .down_data(dd_l), .down_last(dl_l), .down_ready(down_ready),
      .state_dbg(st_l)
   );

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // compare process: outputs sampled on the falling edge, model advanced after
   always @(negedge clk) begin
      logic       ur_e;
      logic [3:0] e_m, e_l;
      cyc++;
      if (!rst) begin
         exp_m.delete();
         exp_l.delete();
      end
      ur_e = (exp_m.size() == 0) || (down_ready && exp_m.size() == 1);
      e_m  = (exp_m.size() == 0) ? 4'b0000 : {2'b11, exp_m[0], exp_m.size() == 1};
      e_l  = (exp_l.size() == 0) ? 4'b0000 : {2'b11, exp_l[0], exp_l.size() == 1};
      check("up_ready_msb", {15'd0, ur_m}, {15'd0, ur_e});
      check("up_ready_lsb", {15'd0, ur_l}, {15'd0, ur_e});
      check("st_v_d_l_msb", {12'd0, st_m, dv_m, dd_m, dl_m}, {12'd0, e_m});
      check("st_v_d_l_lsb", {12'd0, st_l, dv_l, dd_l, dl_l}, {12'd0, e_l});
      if (rst) begin
         if (dv_m && down_ready) begin
            cap_m.push_back(dd_m);
            lst_m.push_back(dl_m);
            fire_cyc.push_back(cyc);
         end
         if (dv_l && down_ready) cap_l.push_back(dd_l);
         if (exp_m.size() != 0 && down_ready) begin
            void'(exp_m.pop_front());
            void'(exp_l.pop_front());
         end
         if (up_valid && ur_e) begin
            for (int i = 0; i < W; i++) begin
               exp_m.push_back(up_data[W-1-i]);
               exp_l.push_back(up_data[i]);
            end
         end
      end
   end

   function automatic logic [15:0] pack_cap(input int which);
      logic [15:0] v;
      v = '0;
      if (which == 0) foreach (cap_m[i]) v = {v[14:0], cap_m[i]};
      if (which == 1) foreach (cap_l[i]) v = {v[14:0], cap_l[i]};
      if (which == 2) foreach (lst_m[i]) v = {v[14:0], lst_m[i]};
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_caps();
      cap_m.delete();
      cap_l.delete();
      lst_m.delete();
      fire_cyc.delete();
   endtask

   task automatic send(input logic [W-1:0] d);
      logic acc;
      int   n;
      up_valid = 1'b1;
      up_data  = d;
      n = 0;
      do begin
         @(negedge clk);
         acc = ur_m;
         tick();
         n++;
      end while (!acc && n < 100);
      if (!acc) check("send_timeout", 16'd0, 16'd1);
      up_valid = 1'b0;
      up_data  = W'($urandom);
   endtask

   task automatic wait_bits(input int n);
      int budget;
      budget = 200;
      while (cap_m.size() < n && budget > 0) begin
         @(negedge clk);
         #1;
         budget--;
      end
      if (cap_m.size() < n) check("wait_bits_timeout", 16'(cap_m.size()), 16'(n));
   endtask

   task automatic word_check(input string nm, input int n, input logic [15:0] m_exp,
                             input logic [15:0] l_exp, input logic [15:0] last_exp);
      wait_bits(n);
      repeat (3) tick();
      check({nm, "_count"}, 16'(cap_m.size()), 16'(n));
      check({nm, "_msb_seq"}, pack_cap(0), m_exp);
      check({nm, "_lsb_seq"}, pack_cap(1), l_exp);
      check({nm, "_last"}, pack_cap(2), last_exp);
   endtask

   initial begin
      // reset with arbitrary inputs
      repeat (3) begin
         up_valid   = 1'($urandom);
         up_data    = W'($urandom);
         down_ready = 1'($urandom);
         tick();
      end
      check("reset_ur", {15'd0, ur_m}, 16'd1);
      check("reset_out", {13'd0, dv_m, dd_m, dl_m}, 16'd0);
      up_valid   = 1'b0;
      down_ready = 1'b1;
      rst = 1'b1;
      repeat (3) tick();

      // single word, MSB-first A5
      clear_caps();
      send(8'hA5);
      word_check("a5", 8, 16'h00A5, 16'h00A5, 16'h0001);
      check("a5_contiguous", 16'(fire_cyc[7] - fire_cyc[0]), 16'd7);

      // 01: LSB instance emits 1 first
      clear_caps();
      send(8'h01);
      word_check("w01", 8, 16'h0001, 16'h0080, 16'h0001);

      // backpressure with down_ready pattern 1,0,0,1,...
      clear_caps();
      fork
         send(8'hC3);
         begin
            logic [3:0] pat;
            pat = 4'b1001;
            for (int i = 0; i < 40; i++) begin
               down_ready = pat[i % 4];
               tick();
            end
         end
      join
      down_ready = 1'b1;
      word_check("c3_bp", 8, 16'h00C3, 16'h00C3, 16'h0001);

      // back-to-back words with no bubble
      clear_caps();
      send(8'hF0);
      send(8'h0F);
      word_check("b2b", 16, 16'hF00F, 16'h0FF0, 16'h0101);
      check("b2b_contiguous", 16'(fire_cyc[15] - fire_cyc[0]), 16'd15);

      // reset mid-word, then a fresh word starts at its first bit
      clear_caps();
      send(8'hFF);
      wait_bits(3);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_ur", {15'd0, ur_m}, 16'd1);
      check("midrst_out_msb", {13'd0, dv_m, dd_m, dl_m}, 16'd0);
      check("midrst_out_lsb", {13'd0, dv_l, dd_l, dl_l}, 16'd0);
      tick();
      tick();
      rst = 1'b1;
      repeat (2) tick();
      clear_caps();
      send(8'h80);
      word_check("w80", 8, 16'h0080, 16'h0001, 16'h0001);

      // randomized traffic with occasional reset pulses
      for (int i = 0; i < 3000; i++) begin
         up_valid   = 1'($urandom_range(0, 1));
         up_data    = W'($urandom);
         down_ready = ($urandom_range(0, 3) != 0);
         rst        = ($urandom_range(0, 199) != 0);
         tick();
      end
      rst = 1'b1;
      up_valid = 1'b0;
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
